// File: rtl/spike_event_encoder.sv
`timescale 1ns/1ps
// Converts the per-neuron valid/spike stream into AER words {spk, eot, ts, idx} in a show-ahead FIFO.
// Latency: one cycle from strobe to ev_valid. The input is never back-pressured; when the FIFO is full, words are dropped and counted.
module spike_event_encoder #(
    parameter int N_NEURONS  = 589,
    parameter int IDX_W      = 10,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int EV_W       = 2 + TS_W + IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic                          in_spike,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [EV_W-1:0]               ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [TS_W-1:0]               timestep
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
    logic [EV_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             is_last, push, pop, full, accept, drop;
    logic [EV_W-1:0]  ev_word;

    always_comb begin
        is_last  = (idx_q == LAST_IDX);
        push     = in_valid && (in_spike || is_last);
        pop      = (level_q != '0) && ev_ready;
        full     = (level_q == FULL_LVL);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        accept   = push && (!full || pop);
        drop     = push && full && !pop;
        ev_word  = {in_spike, is_last, ts_q, idx_q};

        idx_d      = idx_q;
        ts_d       = ts_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (clear) begin
            idx_d      = '0;
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (in_valid) begin
                if (is_last) begin
                    idx_d = '0;
                    ts_d  = ts_q + TS_W'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            if (accept) begin
                mem_d[wr_ptr_q] = ev_word;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(accept) - LVL_W'(pop);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: nothing is read out unless level_q marks it as written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev_valid   = (level_q != '0);
    assign ev_data    = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign timestep   = ts_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
`timescale 1ns/1ps
// Directed bench for spike_event_encoder with N_NEURONS=4, TS_W=2, FIFO_DEPTH=4.
module tb_spike_event_encoder;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_spike, ev_ready;
    logic       ev_valid, overflow;
    logic [5:0] ev_data;
    logic [2:0] fifo_level;
    logic [15:0] drop_cnt;
    logic [1:0] timestep;

    int checks = 0;
    int failures = 0;

    spike_event_encoder #(
        .N_NEURONS(4), .IDX_W(2), .TS_W(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_spike(in_spike),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .fifo_level(fifo_level),
        .overflow(overflow), .drop_cnt(drop_cnt), .timestep(timestep)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0; in_spike = 1'b0;
        edge1();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_spike = 1'b0; ev_ready = 1'b0;
        edge1(); edge1();
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid got=%0h exp=0", ev_valid); end
        checks++; if (ev_data !== 6'h00) begin failures++; $display("FAIL reset_ev_data got=%0h exp=0", ev_data); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_status got ovf=%0b drop=%0d exp 0/0", overflow, drop_cnt); end
        checks++; if (timestep !== 2'd0) begin failures++; $display("FAIL reset_timestep got=%0d exp=0", timestep); end
        rst = 1'b1;
        edge1();
    endtask

    task automatic test_no_spikes();
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_spike = 1'b0;
            edge1();
        end
        in_valid = 1'b0;
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL nospk_level got=%0d exp=2", fifo_level); end
        checks++; if (timestep !== 2'd2) begin failures++; $display("FAIL nospk_timestep got=%0d exp=2", timestep); end
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h13) begin failures++; $display("FAIL nospk_word0 got v=%0b d=%0h exp v=1 d=13", ev_valid, ev_data); end
        ev_ready = 1'b1;
        edge1();
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h17) begin failures++; $display("FAIL nospk_word1 got v=%0b d=%0h exp v=1 d=17", ev_valid, ev_data); end
        edge1();
        checks++; if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL nospk_drained got v=%0b lvl=%0d exp 0/0", ev_valid, fifo_level); end
        ev_ready = 1'b0;
    endtask

    task automatic test_spikes_ready();
        do_clear();
        ev_ready = 1'b1;
        in_valid = 1'b1; in_spike = 1'b0; edge1();
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL spk_idx0_novalid got=%0b exp=0", ev_valid); end
        in_spike = 1'b1; edge1();
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h21) begin failures++; $display("FAIL spk_idx1 got v=%0b d=%0h exp v=1 d=21", ev_valid, ev_data); end
        in_spike = 1'b0; edge1();
        checks++; if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL spk_pop1 got v=%0b lvl=%0d exp 0/0", ev_valid, fifo_level); end
        in_spike = 1'b1; edge1();
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h33) begin failures++; $display("FAIL spk_idx3_eot got v=%0b d=%0h exp v=1 d=33", ev_valid, ev_data); end
        in_valid = 1'b0; in_spike = 1'b0; edge1();
        checks++; if (fifo_level !== 3'd0 || timestep !== 2'd1) begin failures++; $display("FAIL spk_end got lvl=%0d ts=%0d exp 0/1", fifo_level, timestep); end
        ev_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [5:0] exp_w [4];
        exp_w[0] = 6'h20; exp_w[1] = 6'h21; exp_w[2] = 6'h22; exp_w[3] = 6'h33;
        do_clear();
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_spike = 1'b1;
            edge1();
        end
        in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h20) begin failures++; $display("FAIL ovf_stall_stable got v=%0b d=%0h exp v=1 d=20", ev_valid, ev_data); end
            edge1();
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_data !== exp_w[i]) begin failures++; $display("FAIL ovf_drain_%0d got v=%0b d=%0h exp v=1 d=%0h", i, ev_valid, ev_data, exp_w[i]); end
            edge1();
        end
        checks++; if (ev_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_drain got v=%0b ovf=%0b exp v=0 ovf=1", ev_valid, overflow); end
        ev_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [5:0] exp_w [4];
        exp_w[0] = 6'h21; exp_w[1] = 6'h22; exp_w[2] = 6'h33; exp_w[3] = 6'h24;
        do_clear();
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_spike = 1'b1;
            edge1();
        end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_filled got=%0d exp=4", fifo_level); end
        ev_ready = 1'b1;
        edge1();
        in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d exp=4", fifo_level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL fpp_no_drop got ovf=%0b drop=%0d exp 0/0", overflow, drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_data !== exp_w[i]) begin failures++; $display("FAIL fpp_drain_%0d got v=%0b d=%0h exp v=1 d=%0h", i, ev_valid, ev_data, exp_w[i]); end
            edge1();
        end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL fpp_empty got=%0d exp=0", fifo_level); end
        ev_ready = 1'b0;
    endtask

    task automatic test_clear_mid();
        do_clear();
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_spike = 1'b1;
            edge1();
        end
        clear = 1'b1; in_valid = 1'b1; in_spike = 1'b1;
        edge1();
        clear = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (fifo_level !== 3'd0 || ev_valid !== 1'b0) begin failures++; $display("FAIL clr_fifo got lvl=%0d v=%0b exp 0/0", fifo_level, ev_valid); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL clr_status got ovf=%0b drop=%0d exp 0/0", overflow, drop_cnt); end
        checks++; if (timestep !== 2'd0) begin failures++; $display("FAIL clr_timestep got=%0d exp=0", timestep); end
        in_valid = 1'b1; in_spike = 1'b1;
        edge1();
        in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h20) begin failures++; $display("FAIL clr_next_strobe got v=%0b d=%0h exp v=1 d=20", ev_valid, ev_data); end
    endtask

    task automatic test_ts_wrap();
        logic [1:0] t;
        logic [5:0] exp_w;
        do_clear();
        ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_spike = 1'b0;
            edge1();
            if (i % 4 == 3) begin
                t = 2'((i / 4) % 4);
                exp_w = {2'b01, t, 2'b11};
                checks++; if (ev_valid !== 1'b1 || ev_data !== exp_w) begin failures++; $display("FAIL wrap_eot_%0d got v=%0b d=%0h exp v=1 d=%0h", i / 4, ev_valid, ev_data, exp_w); end
            end
        end
        in_valid = 1'b0;
        edge1();
        checks++; if (timestep !== 2'd1) begin failures++; $display("FAIL wrap_timestep got=%0d exp=1", timestep); end
        ev_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_spike = 1'b1;
            edge1();
        end
        in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (fifo_level !== 3'd4 || overflow !== 1'b1 || timestep !== 2'd1) begin failures++; $display("FAIL arst_pre got lvl=%0d ovf=%0b ts=%0d exp 4/1/1", fifo_level, overflow, timestep); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ev_valid !== 1'b0 || ev_data !== 6'h00 || fifo_level !== 3'd0) begin failures++; $display("FAIL arst_fifo got v=%0b d=%0h lvl=%0d exp 0/0/0", ev_valid, ev_data, fifo_level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || timestep !== 2'd0) begin failures++; $display("FAIL arst_status got ovf=%0b drop=%0d ts=%0d exp 0/0/0", overflow, drop_cnt, timestep); end
        #2 rst = 1'b1;
        in_valid = 1'b1; in_spike = 1'b1;
        edge1();
        in_valid = 1'b0; in_spike = 1'b0;
        checks++; if (ev_valid !== 1'b1 || ev_data !== 6'h20) begin failures++; $display("FAIL arst_next_strobe got v=%0b d=%0h exp v=1 d=20", ev_valid, ev_data); end
    endtask

    initial begin
        test_reset();
        test_no_spikes();
        test_spikes_ready();
        test_overflow();
        test_full_push_pop();
        test_clear_mid();
        test_ts_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
